mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter INIT_DATA, default 8'h00, value loaded into every memory word on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port addr  input  5  word address, 32 words.
REQ-005 SHALL have port data_in  input  8  write data.
REQ-006 SHALL have port read  input  1  read strobe from driver.
REQ-007 SHALL have port write  input  1  write strobe from driver.
REQ-008 SHALL have port data_out  output  8  read data.
REQ-009 SHALL have port par_inject  input  1  force bad parity on the next write (parity build only).
REQ-010 SHALL have port err  output  1  sticky read/write collision flag.
REQ-011 SHALL have port par_err  output  1  sticky parity mismatch flag.
REQ-012 SHALL have port wr_count  output  8  accepted write accesses, saturating.
REQ-013 SHALL have port rd_count  output  8  accepted read accesses, saturating.

Function
REQ-014 SHALL store 32 x 8-bit words; write with write=1, read=0 at posedge stores data_in at mem[addr].
REQ-015 SHALL drive data_out combinationally as mem[addr] while read=1, so data is valid at the first posedge after the driver raises read on a negedge.
REQ-016 SHALL hold data_out at the last value sampled at a posedge with read=1 while read=0 (hold register, reset to 8'h00).
REQ-017 SHALL run FSM IDLE/WR/RD: IDLE->WR on write=1 & read=0; IDLE->RD on read=1 & write=0; WR->IDLE on write=0; RD->IDLE on read=0; WR<->RD direct on strobe swap.
REQ-018 SHALL increment wr_count on each IDLE->WR or RD->WR transition; rd_count on each IDLE->RD or WR->RD transition (one count per strobe assertion, regardless of held cycles).
REQ-019 SHALL saturate both counters at 8'hFF; no wrap.
REQ-020 SHALL, when read=1 & write=1 at a posedge, suppress the write, serve the read, set err=1, leave FSM state and counters unchanged.
REQ-021 SHALL keep err and par_err set until rst; only rst clears them.
REQ-022 SHALL update a write held over multiple cycles every cycle (last data_in wins), with one count.
REQ-023 SHALL treat addr as 5-bit unsigned; no out-of-range case exists.

Reset
REQ-024 SHALL, on posedge clk with rst=1, load INIT_DATA into all 32 words, clear the hold register, counters, err, par_err, and enter IDLE.
REQ-025 SHALL give rst priority over any concurrent read/write; an access in progress is dropped and not counted.
REQ-026 SHALL, with rst and read both high, drive data_out = INIT_DATA only after the reset edge; before it, the combinational read shows current content.

Configuration
REQ-027 SHALL, with MEM_PARITY_EN defined, store an even-parity bit per word computed from data_in at write (inverted if par_inject=1 at that edge), reset parity consistent with INIT_DATA.
REQ-028 SHALL, with MEM_PARITY_EN defined, set par_err at a posedge with read=1 whose addressed word fails parity check.
REQ-029 SHALL, without MEM_PARITY_EN, omit parity storage, tie par_err to 0, and ignore par_inject.

Verification
REQ-030 SHALL cover: rst, write 0x1F<-8'hA5, read 0x1F -> data_out=8'hA5 at sampling posedge, wr_count=1, rd_count=1.
REQ-031 SHALL cover: read any address after rst with INIT_DATA=8'h3C -> 8'h3C; data_out holds 8'h3C after read drops.
REQ-032 SHALL cover: read=write=1, addr 0x05, data_in 8'h77 over word 8'h00 -> err=1, mem[5] stays 8'h00, counters unchanged.
REQ-033 SHALL cover: 300 write strobes -> wr_count=8'hFF; write held 4 cycles -> counted once.
REQ-034 SHALL cover: with MEM_PARITY_EN, write 0x02 with par_inject=1, read 0x02 -> par_err=1; without macro -> par_err=0.
REQ-035 SHALL cover: rst asserted mid-write to 0x10 -> mem[0x10]=INIT_DATA, counters 0, FSM IDLE.

Source files
------------

// File: rtl/mem_responder.sv
// 32 x 8 memory slave with strobe FSM, saturating access counters and sticky error flags.
// Optional per-word even parity is built when MEM_PARITY_EN is defined.
module mem_responder #(
  parameter logic [7:0] INIT_DATA = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] addr,
  input  logic [7:0] data_in,
  input  logic       read,
  input  logic       write,
  output logic [7:0] data_out,
  input  logic       par_inject,
  output logic       err,
  output logic       par_err,
  output logic [7:0] wr_count,
  output logic [7:0] rd_count
);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t     state_q, state_d;
  logic [7:0] mem_q [32];
  logic [7:0] hold_q;
  logic [7:0] wr_count_q, rd_count_q;
  logic       err_q;
  logic       wr_en, rd_only, collide;
  logic       wr_inc, rd_inc;

  assign collide = read & write;
  assign wr_en   = write & ~read;
  assign rd_only = read & ~write;

  // A collision holds state, so an ongoing strobe is not re-counted afterwards.
  always_comb begin
    state_d = state_q;
    wr_inc  = 1'b0;
    rd_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_en) begin
          state_d = WR;
          wr_inc  = 1'b1;
        end else if (rd_only) begin
          state_d = RD;
          rd_inc  = 1'b1;
        end
      end
      WR: begin
        if (rd_only) begin
          state_d = RD;
          rd_inc  = 1'b1;
        end else if (!write) begin
          state_d = IDLE;
        end
      end
      RD: begin
        if (wr_en) begin
          state_d = WR;
          wr_inc  = 1'b1;
        end else if (!read) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= INIT_DATA;
    end else if (wr_en) begin
      mem_q[addr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q     <= 8'h00;
      wr_count_q <= 8'h00;
      rd_count_q <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      if (read) hold_q <= mem_q[addr];
      if (collide) err_q <= 1'b1;
      if (wr_inc && wr_count_q != 8'hFF) wr_count_q <= wr_count_q + 8'd1;
      if (rd_inc && rd_count_q != 8'hFF) rd_count_q <= rd_count_q + 8'd1;
    end
  end

  assign data_out = read ? mem_q[addr] : hold_q;
  assign err      = err_q;
  assign wr_count = wr_count_q;
  assign rd_count = rd_count_q;

`ifdef MEM_PARITY_EN
  logic [31:0] par_q;
  logic        par_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_q     <= {32{^INIT_DATA}};
      par_err_q <= 1'b0;
    end else begin
      if (wr_en) par_q[addr] <= (^data_in) ^ par_inject;
      if (read && ((^mem_q[addr]) != par_q[addr])) par_err_q <= 1'b1;
    end
  end

  assign par_err = par_err_q;
`else
  logic unused_par_inject;
  assign unused_par_inject = par_inject;
  assign par_err           = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Randomized + directed bench for mem_responder against a behavioural access model.
module tb_mem_responder;
  localparam logic [7:0] INIT = 8'h3C;
`ifdef MEM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, read, write, par_inject;
  logic [4:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out, wr_count, rd_count;
  logic       err, par_err;

  int total = 0;
  int bad   = 0;

  // reference model
  logic [7:0] m_mem [32];
  bit         m_par [32];
  logic [7:0] m_hold;
  int         m_wc, m_rc;
  bit         m_err, m_perr;
  int         m_last;  // 0 none, 1 write strobe, 2 read strobe

  mem_responder #(.INIT_DATA(INIT)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .read(read), .write(write),
    .data_out(data_out), .par_inject(par_inject), .err(err), .par_err(par_err),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i] = INIT;
        m_par[i] = ^INIT;
      end
      m_hold = 8'h00; m_wc = 0; m_rc = 0; m_err = 0; m_perr = 0; m_last = 0;
    end else if (read && write) begin
      m_hold = m_mem[addr];
      m_err  = 1;
      if (PAR_EN && (^m_mem[addr]) != m_par[addr]) m_perr = 1;
    end else if (write) begin
      m_mem[addr] = data_in;
      m_par[addr] = (^data_in) ^ par_inject;
      if (m_last != 1 && m_wc < 255) m_wc++;
      m_last = 1;
    end else if (read) begin
      m_hold = m_mem[addr];
      if (PAR_EN && (^m_mem[addr]) != m_par[addr]) m_perr = 1;
      if (m_last != 2 && m_rc < 255) m_rc++;
      m_last = 2;
    end else begin
      m_last = 0;
    end
  endtask

  // Apply inputs (called at a negedge), clock once, check all outputs at the next negedge.
  task automatic step(input bit rs, input bit r, input bit w, input logic [4:0] a,
                      input logic [7:0] d, input bit inj);
    rst = rs; read = r; write = w; addr = a; data_in = d; par_inject = inj;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("data_out", data_out, read ? m_mem[addr] : m_hold);
    check("wr_count", wr_count, 8'(m_wc));
    check("rd_count", rd_count, 8'(m_rc));
    check("err", {7'd0, err}, {7'd0, m_err});
    check("par_err", {7'd0, par_err}, {7'd0, m_perr});
  endtask

  initial begin
    rst = 1; read = 0; write = 0; addr = 0; data_in = 0; par_inject = 0;
    @(negedge clk);
    // reset with read high: data_out shows INIT after the edge
    step(1, 1, 0, 5'd3, 8'h00, 0);
    check("rst_data", data_out, INIT);
    step(1, 0, 0, 5'd0, 8'h00, 0);
    check("rst_hold", data_out, 8'h00);
    check("rst_wc", wr_count, 8'h00);

    // write 0x1F <- A5, read it back
    step(0, 0, 1, 5'h1F, 8'hA5, 0);
    step(0, 0, 0, 5'h1F, 8'h00, 0);
    step(0, 1, 0, 5'h1F, 8'h00, 0);
    check("rd_1F", data_out, 8'hA5);
    check("wc_1", wr_count, 8'd1);
    check("rc_1", rd_count, 8'd1);
    step(0, 0, 0, 5'h00, 8'h00, 0);
    check("hold_A5", data_out, 8'hA5);

    // untouched word reads INIT and is held afterwards
    step(0, 1, 0, 5'h07, 8'h00, 0);
    check("rd_init", data_out, INIT);
    step(0, 0, 0, 5'h02, 8'h00, 0);
    check("hold_init", data_out, INIT);

    // collision over a zero word
    step(0, 0, 1, 5'h05, 8'h00, 0);
    step(0, 0, 0, 5'h05, 8'h00, 0);
    step(0, 1, 1, 5'h05, 8'h77, 0);
    check("col_err", {7'd0, err}, 8'd1);
    check("col_wc", wr_count, 8'd2);
    step(0, 0, 0, 5'h05, 8'h00, 0);
    step(0, 1, 0, 5'h05, 8'h00, 0);
    check("col_mem", data_out, 8'h00);

    // write held 4 cycles, last data wins, one count
    step(0, 0, 1, 5'h09, 8'h11, 0);
    step(0, 0, 1, 5'h09, 8'h22, 0);
    step(0, 0, 1, 5'h09, 8'h33, 0);
    step(0, 0, 1, 5'h09, 8'h44, 0);
    check("held_wc", wr_count, 8'd3);
    step(0, 1, 0, 5'h09, 8'h00, 0);
    check("held_data", data_out, 8'h44);

    // reset in the middle of a write to 0x10
    step(0, 0, 1, 5'h10, 8'h99, 0);
    step(1, 0, 1, 5'h10, 8'h5A, 0);
    check("midrst_wc", wr_count, 8'd0);
    check("midrst_err", {7'd0, err}, 8'd0);
    step(0, 1, 0, 5'h10, 8'h00, 0);
    check("midrst_mem", data_out, INIT);
    check("midrst_rc", rd_count, 8'd1);

    // parity injection on 0x02
    step(0, 0, 1, 5'h02, 8'h81, 1);
    step(0, 1, 0, 5'h02, 8'h00, 0);
    check("par_inj", {7'd0, par_err}, {7'd0, PAR_EN});

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           5'($urandom_range(0, 31)), 8'($urandom), ($urandom_range(0, 9) == 0));
    end

    // saturation: 300 separate write strobes
    step(1, 0, 0, 5'd0, 8'h00, 0);
    for (int n = 0; n < 300; n++) begin
      step(0, 0, 1, 5'(n), 8'(n), 0);
      step(0, 0, 0, 5'(n), 8'(n), 0);
    end
    check("wc_sat", wr_count, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
